// File: rtl/sdram_rank_array.sv
// Multi-rank, multi-lane SDRAM array: steers per-rank chip selects from the rank latched at ACTIVE,
// tracks open banks and flags the first protocol violation. Includes a compact x16 chip model.

module sdram_chip_x16 #(
    parameter int ROW_W = 13
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             cs_n_i,
    input  logic             ras_n_i,
    input  logic             cas_n_i,
    input  logic             we_n_i,
    input  logic [ROW_W-1:0] addr_i,
    input  logic [1:0]       ba_i,
    input  logic [1:0]       dqm_i,
    inout  wire  [15:0]      dq_io
);
    // Storage covers only the low row/column bits; enough to tell locations apart in a rank.
    logic [15:0]      mem [1024];
    logic [3:0][3:0]  row_q;
    logic [1:0]       rd_pipe_q;
    logic [15:0]      rdata_q, rdata2_q;
    logic             vld, is_act, is_rd, is_wr;
    logic [9:0]       idx;
    logic             unused_addr;

    assign vld         = cke_i && !cs_n_i;
    assign is_act      = vld && ({ras_n_i, cas_n_i, we_n_i} == 3'b011);
    assign is_rd       = vld && ({ras_n_i, cas_n_i, we_n_i} == 3'b101);
    assign is_wr       = vld && ({ras_n_i, cas_n_i, we_n_i} == 3'b100);
    assign idx         = {ba_i, row_q[ba_i], addr_i[3:0]};
    assign unused_addr = ^addr_i[ROW_W-1:4];

    always_ff @(posedge clk_i) begin
        if (is_act) row_q[ba_i] <= addr_i[3:0];
        if (is_wr) begin
            if (!dqm_i[0]) mem[idx][7:0]  <= dq_io[7:0];
            if (!dqm_i[1]) mem[idx][15:8] <= dq_io[15:8];
        end
        if (is_rd) rdata_q <= mem[idx];
        rdata2_q  <= rdata_q;
        rd_pipe_q <= {rd_pipe_q[0], is_rd};
    end

    // CAS latency 2, burst of one: data is on the bus for the edge two clocks after RD.
    assign dq_io = rd_pipe_q[1] ? rdata2_q : 16'hzzzz;
endmodule

module sdram_rank_array #(
    parameter  int LANES  = 2,
    parameter  int RANKS  = 2,
    parameter  int ROW_W  = 13,
    localparam int RANK_W = (RANKS > 1) ? $clog2(RANKS) : 0,
    localparam int AW     = ROW_W + RANK_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cke,
    input  logic                 cs,
    input  logic                 ras,
    input  logic                 cas,
    input  logic                 we,
    input  logic [AW-1:0]        a,
    input  logic [1:0]           ba,
    input  logic [2*LANES-1:0]   dqm,
    inout  wire  [16*LANES-1:0]  dq,
    output logic [3:0]           bank_open,
    output logic                 proto_err,
    output logic [2:0]           err_code
);
    localparam int RW1 = (RANK_W > 0) ? RANK_W : 1;

    typedef enum logic [2:0] {
        C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
        C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
    } cmd_e;

    cmd_e                  cmd;
    logic                  vld;
    logic [RW1-1:0]        act_rank;
    logic [RANKS-1:0]      cs_r;
    logic [3:0][RW1-1:0]   rank_q, rank_d;
    logic [3:0]            open_q, open_d;
    logic                  err_q, err_d;
    logic [2:0]            code_q, code_d;

    assign cmd = cmd_e'({ras, cas, we});
    assign vld = cke && !cs;

    if (RANK_W > 0) begin : g_rank_bits
        assign act_rank = a[AW-1:ROW_W];
    end else begin : g_no_rank_bits
        assign act_rank = '0;
    end

    if (RANKS > 1) begin : g_steer
        always_comb begin
            cs_r = '1;
            if (vld) begin
                case (cmd)
                    C_ACT:              cs_r[act_rank] = 1'b0;
                    C_RD, C_WR, C_BST:  cs_r[rank_q[ba]] = 1'b0;
                    C_PRE: begin
                        if (a[10]) cs_r = '0;
                        else       cs_r[rank_q[ba]] = 1'b0;
                    end
                    C_REF, C_MRS:       cs_r = '0;
                    default:            cs_r = '1;
                endcase
            end
        end
    end else begin : g_single
        assign cs_r = cs;
    end

    always_comb begin
        rank_d = rank_q;
        open_d = open_q;
        err_d  = err_q;
        code_d = code_q;
        if (vld) begin
            case (cmd)
                C_ACT: begin
                    rank_d[ba] = act_rank;
                    open_d[ba] = 1'b1;
                end
                C_PRE: begin
                    if (a[10]) open_d = '0;
                    else       open_d[ba] = 1'b0;
                end
                C_RD, C_WR: if (a[10]) open_d[ba] = 1'b0;
                default: ;
            endcase
            // Only the first violation is recorded; the command still reaches the chips.
            if (!err_q) begin
                if ((cmd == C_RD || cmd == C_WR) && !open_q[ba]) begin
                    err_d = 1'b1; code_d = 3'd1;
                end else if (cmd == C_ACT && open_q[ba]) begin
                    err_d = 1'b1; code_d = 3'd2;
                end else if (cmd == C_REF && |open_q) begin
                    err_d = 1'b1; code_d = 3'd3;
                end else if (cmd == C_MRS && |open_q) begin
                    err_d = 1'b1; code_d = 3'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rank_q <= '0;
            open_q <= '0;
            err_q  <= 1'b0;
            code_q <= '0;
        end else begin
            rank_q <= rank_d;
            open_q <= open_d;
            err_q  <= err_d;
            code_q <= code_d;
        end
    end

    assign bank_open = open_q;
    assign proto_err = err_q;
    assign err_code  = code_q;

    for (genvar r = 0; r < RANKS; r++) begin : g_rank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sdram_chip_x16 #(.ROW_W(ROW_W)) u_chip (
                .clk_i   (clk),
                .cke_i   (cke),
                .cs_n_i  (cs_r[r]),
                .ras_n_i (ras),
                .cas_n_i (cas),
                .we_n_i  (we),
                .addr_i  (a[ROW_W-1:0]),
                .ba_i    (ba),
                .dqm_i   (dqm[2*l +: 2]),
                .dq_io   (dq[16*l +: 16])
            );
        end
    end
endmodule
